// File: rtl/led_gui_menu_nav.sv
// Two-level menu navigator for the LED GUI: top item and sub-item cursors, with a
// remembered sub position per top item. Define MENU_WRAP_EN to wrap cursors at the ends.
module led_gui_menu_nav #(
    parameter int TOP_N = 3,
    parameter int SUB_N = 3,
    localparam int TW = (TOP_N > 1) ? $clog2(TOP_N) : 1,
    localparam int SW = (SUB_N > 1) ? $clog2(SUB_N) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [3:0]               config_sig,
    output logic [TOP_N-1:0]         menu_top,
    output logic [TOP_N*SUB_N-1:0]   menu_sub,
    output logic                     level,
    output logic [TW-1:0]            top_idx,
    output logic [SW-1:0]            sub_idx,
    output logic                     sel_pulse
);

    localparam int TS = TOP_N * SUB_N;

    typedef enum logic [0:0] {
        TOP = 1'b0,
        SUB = 1'b1
    } state_t;

    state_t              state, state_nxt;
    logic [TW-1:0]       top_nxt;
    logic [SW-1:0]       sub_nxt;
    logic                mem_wr;
    logic                sel_nxt;
    logic [TOP_N-1:0]    top_oh_nxt;
    logic [TS-1:0]       sub_oh_nxt;
    int                  sub_shift;
    logic [SW-1:0]       mem [TOP_N];

    logic key_up, key_down, key_left, key_right;
    assign key_up    = config_sig[3];
    assign key_down  = config_sig[2];
    assign key_left  = config_sig[1];
    assign key_right = config_sig[0];

    function automatic logic [TW-1:0] top_dec(input logic [TW-1:0] i);
`ifdef MENU_WRAP_EN
        return (i == '0) ? TW'(TOP_N - 1) : i - TW'(1);
`else
        return (i == '0) ? i : i - TW'(1);
`endif
    endfunction

    function automatic logic [TW-1:0] top_inc(input logic [TW-1:0] i);
`ifdef MENU_WRAP_EN
        return (i == TW'(TOP_N - 1)) ? '0 : i + TW'(1);
`else
        return (i == TW'(TOP_N - 1)) ? i : i + TW'(1);
`endif
    endfunction

    function automatic logic [SW-1:0] sub_dec(input logic [SW-1:0] i);
`ifdef MENU_WRAP_EN
        return (i == '0) ? SW'(SUB_N - 1) : i - SW'(1);
`else
        return (i == '0) ? i : i - SW'(1);
`endif
    endfunction

    function automatic logic [SW-1:0] sub_inc(input logic [SW-1:0] i);
`ifdef MENU_WRAP_EN
        return (i == SW'(SUB_N - 1)) ? '0 : i + SW'(1);
`else
        return (i == SW'(SUB_N - 1)) ? i : i + SW'(1);
`endif
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= TOP;
        end else begin
            state <= state_nxt;
        end
    end

    // Only the highest-priority key is acted on: left > up > down > right.
    always_comb begin
        state_nxt = state;
        top_nxt   = top_idx;
        sub_nxt   = sub_idx;
        mem_wr    = 1'b0;
        sel_nxt   = 1'b0;
        case (state)
            TOP: begin
                if (key_left) begin
                    state_nxt = TOP;
                end else if (key_up) begin
                    top_nxt = top_dec(top_idx);
                end else if (key_down) begin
                    top_nxt = top_inc(top_idx);
                end else if (key_right) begin
                    state_nxt = SUB;
                    sub_nxt   = mem[top_idx];
                end
            end
            SUB: begin
                if (key_left) begin
                    state_nxt = TOP;
                end else if (key_up) begin
                    sub_nxt = sub_dec(sub_idx);
                    mem_wr  = 1'b1;
                end else if (key_down) begin
                    sub_nxt = sub_inc(sub_idx);
                    mem_wr  = 1'b1;
                end else if (key_right) begin
                    sel_nxt = 1'b1;
                end
            end
            default: state_nxt = TOP;
        endcase
    end

    // Highlight maps are built from the next cursor so they land in the same cycle as the indices.
    always_comb begin
        top_oh_nxt = TOP_N'(1) << (TOP_N - 1 - int'(top_nxt));
        sub_shift  = (TOP_N - 1 - int'(top_nxt)) * SUB_N + (SUB_N - 1 - int'(sub_nxt));
        sub_oh_nxt = '0;
        if (state_nxt == SUB) begin
            sub_oh_nxt = TS'(1) << sub_shift;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top_idx   <= '0;
            sub_idx   <= '0;
            for (int i = 0; i < TOP_N; i++) begin
                mem[i] <= '0;
            end
            menu_top  <= {1'b1, {(TOP_N-1){1'b0}}};
            menu_sub  <= '0;
            sel_pulse <= 1'b0;
        end else begin
            top_idx   <= top_nxt;
            sub_idx   <= sub_nxt;
            if (mem_wr) begin
                mem[top_idx] <= sub_nxt;
            end
            menu_top  <= top_oh_nxt;
            menu_sub  <= sub_oh_nxt;
            sel_pulse <= sel_nxt;
        end
    end

    assign level = (state == SUB);

endmodule

// File: tb/tb_led_gui_menu_nav.sv
// Self-checking bench for led_gui_menu_nav (TOP_N=3, SUB_N=3): table-driven key vectors
// with a scoreboard queue, plus an asynchronous reset sequence mid sub-menu.
module tb_led_gui_menu_nav;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] config_sig;
    logic [2:0] menu_top;
    logic [8:0] menu_sub;
    logic       level;
    logic [1:0] top_idx;
    logic [1:0] sub_idx;
    logic       sel_pulse;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      name;
        logic [3:0] cfg;
        logic [1:0] top;
        logic       lvl;
        logic [1:0] sub;
        logic       sel;
        logic [2:0] mtop;
        logic [8:0] msub;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    led_gui_menu_nav #(.TOP_N(3), .SUB_N(3)) dut (
        .clk(clk),
        .rst(rst),
        .config_sig(config_sig),
        .menu_top(menu_top),
        .menu_sub(menu_sub),
        .level(level),
        .top_idx(top_idx),
        .sub_idx(sub_idx),
        .sel_pulse(sel_pulse)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input string n, input logic [3:0] c, input logic [1:0] t,
                                input logic l, input logic [1:0] s, input logic sl,
                                input logic [2:0] mt, input logic [8:0] ms);
        vec_t v;
        v.name = n; v.cfg = c; v.top = t; v.lvl = l; v.sub = s; v.sel = sl;
        v.mtop = mt; v.msub = ms;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input vec_t v);
        chk({v.name, ".top_idx"}, 32'(top_idx), 32'(v.top));
        chk({v.name, ".level"}, 32'(level), 32'(v.lvl));
        chk({v.name, ".sel_pulse"}, 32'(sel_pulse), 32'(v.sel));
        chk({v.name, ".menu_top"}, 32'(menu_top), 32'(v.mtop));
        chk({v.name, ".menu_sub"}, 32'(menu_sub), 32'(v.msub));
        if (v.lvl) chk({v.name, ".sub_idx"}, 32'(sub_idx), 32'(v.sub));
    endtask

    task automatic checkReset(input string name);
        chk({name, ".top_idx"}, 32'(top_idx), 32'd0);
        chk({name, ".level"}, 32'(level), 32'd0);
        chk({name, ".sel_pulse"}, 32'(sel_pulse), 32'd0);
        chk({name, ".menu_top"}, 32'(menu_top), 32'b100);
        chk({name, ".menu_sub"}, 32'(menu_sub), 32'd0);
    endtask

    // Outputs from the previous edge are compared at this falling edge, then the next key is driven.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        if (sb.size() > 0) checkOutput(sb.pop_front());
        config_sig = v.cfg;
        sb.push_back(v);
    endtask

    task automatic drain();
        @(negedge clk);
        if (sb.size() > 0) checkOutput(sb.pop_front());
        config_sig = 4'b0000;
    endtask

    initial begin
        vecs.push_back(mk("idle",        4'b0000, 2'd0, 0, 2'd0, 0, 3'b100, 9'b000_000_000));
        vecs.push_back(mk("down1",       4'b0100, 2'd1, 0, 2'd0, 0, 3'b010, 9'b000_000_000));
        vecs.push_back(mk("down2",       4'b0100, 2'd2, 0, 2'd0, 0, 3'b001, 9'b000_000_000));
`ifdef MENU_WRAP_EN
        vecs.push_back(mk("down3_wrap",  4'b0100, 2'd0, 0, 2'd0, 0, 3'b100, 9'b000_000_000));
        vecs.push_back(mk("realign",     4'b0100, 2'd1, 0, 2'd0, 0, 3'b010, 9'b000_000_000));
`else
        vecs.push_back(mk("down3_hold",  4'b0100, 2'd2, 0, 2'd0, 0, 3'b001, 9'b000_000_000));
        vecs.push_back(mk("realign",     4'b1000, 2'd1, 0, 2'd0, 0, 3'b010, 9'b000_000_000));
`endif
        vecs.push_back(mk("enter1",      4'b0001, 2'd1, 1, 2'd0, 0, 3'b010, 9'b000_100_000));
`ifdef MENU_WRAP_EN
        vecs.push_back(mk("sub_up_wrap", 4'b1000, 2'd1, 1, 2'd2, 0, 3'b010, 9'b000_001_000));
        vecs.push_back(mk("sub_to1",     4'b1000, 2'd1, 1, 2'd1, 0, 3'b010, 9'b000_010_000));
`else
        vecs.push_back(mk("sub_up_hold", 4'b1000, 2'd1, 1, 2'd0, 0, 3'b010, 9'b000_100_000));
        vecs.push_back(mk("sub_to1",     4'b0100, 2'd1, 1, 2'd1, 0, 3'b010, 9'b000_010_000));
`endif
        vecs.push_back(mk("leave1",      4'b0010, 2'd1, 0, 2'd0, 0, 3'b010, 9'b000_000_000));
        vecs.push_back(mk("prio_down",   4'b0101, 2'd2, 0, 2'd0, 0, 3'b001, 9'b000_000_000));
        vecs.push_back(mk("up_back",     4'b1000, 2'd1, 0, 2'd0, 0, 3'b010, 9'b000_000_000));
        vecs.push_back(mk("left_top",    4'b0010, 2'd1, 0, 2'd0, 0, 3'b010, 9'b000_000_000));
        vecs.push_back(mk("reenter1",    4'b0001, 2'd1, 1, 2'd1, 0, 3'b010, 9'b000_010_000));
        vecs.push_back(mk("select",      4'b0001, 2'd1, 1, 2'd1, 1, 3'b010, 9'b000_010_000));
        vecs.push_back(mk("sel_drop",    4'b0000, 2'd1, 1, 2'd1, 0, 3'b010, 9'b000_010_000));
        vecs.push_back(mk("prio_left",   4'b1110, 2'd1, 0, 2'd0, 0, 3'b010, 9'b000_000_000));
        vecs.push_back(mk("up_to0",      4'b1000, 2'd0, 0, 2'd0, 0, 3'b100, 9'b000_000_000));
        vecs.push_back(mk("enter0",      4'b0001, 2'd0, 1, 2'd0, 0, 3'b100, 9'b100_000_000));
        vecs.push_back(mk("sub_down1",   4'b0100, 2'd0, 1, 2'd1, 0, 3'b100, 9'b010_000_000));
        vecs.push_back(mk("sub_down2",   4'b0100, 2'd0, 1, 2'd2, 0, 3'b100, 9'b001_000_000));
`ifdef MENU_WRAP_EN
        vecs.push_back(mk("sub_dn_wrap", 4'b0100, 2'd0, 1, 2'd0, 0, 3'b100, 9'b100_000_000));
        vecs.push_back(mk("sub_back2",   4'b1000, 2'd0, 1, 2'd2, 0, 3'b100, 9'b001_000_000));
`else
        vecs.push_back(mk("sub_dn_hold", 4'b0100, 2'd0, 1, 2'd2, 0, 3'b100, 9'b001_000_000));
        vecs.push_back(mk("sub_idle",    4'b0000, 2'd0, 1, 2'd2, 0, 3'b100, 9'b001_000_000));
`endif
        vecs.push_back(mk("prio_up",     4'b1001, 2'd0, 1, 2'd1, 0, 3'b100, 9'b010_000_000));
        vecs.push_back(mk("sub_to2",     4'b0100, 2'd0, 1, 2'd2, 0, 3'b100, 9'b001_000_000));

        rst = 1'b1;
        config_sig = 4'b0000;
        repeat (3) @(negedge clk);
        checkReset("reset");
        rst = 1'b0;

        foreach (vecs[i]) applyStimulus(vecs[i]);
        drain();

        // Asynchronous reset while inside item 0 at sub_idx 2, away from any clock edge.
        #2 rst = 1'b1;
        #1 checkReset("async_reset");
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(mk("reenter_after_rst", 4'b0001, 2'd0, 1, 2'd0, 0, 3'b100, 9'b100_000_000));
        applyStimulus(mk("idle_after_rst",    4'b0000, 2'd0, 1, 2'd0, 0, 3'b100, 9'b100_000_000));
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
